// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM encoding,
// protocol header sizes and the IP total-length helper.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_BUSY  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int IP_HDR_LEN      = 20;
    localparam int UDP_HDR_LEN     = 8;
    localparam int DEF_MAX_PAYLOAD = 1472;

    // IP total length covers the IP header, the UDP header and the payload.
    function automatic logic [15:0] ip_total_len(input logic [15:0] udp_len);
        return udp_len + 16'(IP_HDR_LEN + UDP_HDR_LEN);
    endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping around. Also used by the receive-side dispatcher.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]         grant_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int IDX_W = $clog2(NUM_CH);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan the channels starting at the pointer; the first requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            pos_idx = IDX_W'(pos);
            if (!valid_o && req_i[pos_idx]) begin
                valid_o          = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP/IP/MAC frame transmitter between
// NUM_CH payload sources. Validates the length, latches the frame header
// parameters, starts the transmitter, routes payload reads to the owner
// and enforces the inter-frame gap. A watchdog flags a hung transmitter.
module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          IFG_CYCLES  = 12,
    parameter int          MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int          TIMEOUT     = 4096,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [16*NUM_CH-1:0] ch_len,
    input  logic [16*NUM_CH-1:0] ch_src_port,
    input  logic [16*NUM_CH-1:0] ch_dst_port,
    input  logic [16*NUM_CH-1:0] ch_data_chksum,
    input  logic [32*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_data_rd,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 ch_err,
    output logic                 tx_start,
    output logic [15:0]          tx_udp_data_length,
    output logic [15:0]          tx_udp_src_port,
    output logic [15:0]          tx_udp_dst_port,
    output logic [15:0]          tx_udp_data_chksum,
    output logic [15:0]          tx_ip_total_len,
    output logic [15:0]          tx_ip_id,
    output logic [31:0]          tx_data_in,
    input  logic                 tx_data_in_rd,
    input  logic                 tx_eop,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    // Watchdog fires on the TIMEOUT-th BUSY clock without tx_eop and then
    // saturates so the counter never wraps into a second event.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    // A zero gap still spends one cycle in GAP.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 1) ? IFG_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [NUM_CH-1:0]   win_oh_q, win_oh_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         src_q, src_d;
    logic [15:0]         dst_q, dst_d;
    logic [15:0]         csum_q, csum_d;
    logic [15:0]         total_q, total_d;
    logic [15:0]         id_q, id_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                tmo_q, tmo_d;

    logic [NUM_CH-1:0]   arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;

    logic [15:0]         sel_len;
    logic [15:0]         sel_src;
    logic [15:0]         sel_dst;
    logic [15:0]         sel_csum;
    logic [31:0]         sel_data;
    logic                too_long;
    logic [IDX_W-1:0]    win_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (ch_req),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Per-channel fields of the current winner.
    assign sel_len  = ch_len[16*int'(win_q) +: 16];
    assign sel_src  = ch_src_port[16*int'(win_q) +: 16];
    assign sel_dst  = ch_dst_port[16*int'(win_q) +: 16];
    assign sel_csum = ch_data_chksum[16*int'(win_q) +: 16];
    assign sel_data = ch_data[32*int'(win_q) +: 32];

    assign too_long = {16'd0, sel_len} > 32'(MAX_PAYLOAD);
    assign win_next = (int'(win_q) == NUM_CH - 1) ? '0 : win_q + 1'b1;

    // State and datapath registers; reset returns everything to idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            win_oh_q <= '0;
            rr_q     <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            csum_q   <= '0;
            total_q  <= '0;
            id_q     <= ID_INIT;
            wd_q     <= '0;
            gap_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            win_oh_q <= win_oh_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            csum_q   <= csum_d;
            total_q  <= total_d;
            id_q     <= id_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
        end
    end

    // Frame sequencing: next state, register updates and per-cycle strobes.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        win_oh_d   = win_oh_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        len_d      = len_q;
        src_d      = src_q;
        dst_d      = dst_q;
        csum_d     = csum_q;
        total_d    = total_q;
        id_d       = id_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        ch_done    = '0;
        ch_err     = 1'b0;
        tx_start   = 1'b0;
        ch_data_rd = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    win_d    = arb_idx;
                    win_oh_d = arb_grant;
                    state_d  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (too_long) begin
                    // Oversized frame: tell the source and move on without
                    // ever touching the transmitter.
                    ch_done = win_oh_q;
                    ch_err  = 1'b1;
                    rr_d    = win_next;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    len_d   = sel_len;
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    csum_d  = sel_csum;
                    total_d = ip_total_len(sel_len);
                    grant_d = win_oh_q;
                    state_d = ST_LOAD;
                end
            end

            // Parameters settle for a full cycle before the start pulse.
            ST_LOAD: begin
                state_d = ST_START;
            end

            ST_START: begin
                tx_start = 1'b1;
                wd_d     = '0;
                state_d  = ST_BUSY;
            end

            ST_BUSY: begin
                ch_data_rd = tx_data_in_rd ? win_oh_q : '0;
                if (tx_eop) begin
                    ch_done = win_oh_q;
                    grant_d = '0;
                    id_d    = id_q + 16'd1;
                    rr_d    = win_next;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    // The transmitter cannot be aborted; only flag the hang.
                    if (wd_q == WD_LAST) begin
                        tmo_d = 1'b1;
                    end
                    if (wd_q != WD_MAX) begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ch_grant           = grant_q;
    assign tx_udp_data_length = len_q;
    assign tx_udp_src_port    = src_q;
    assign tx_udp_dst_port    = dst_q;
    assign tx_udp_data_chksum = csum_q;
    assign tx_ip_total_len    = total_q;
    assign tx_ip_id           = id_q;
    assign tx_data_in         = (grant_q != '0) ? sel_data : 32'd0;
    assign busy               = (state_q != ST_IDLE);
    assign timeout_err        = tmo_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Testbench for udp_tx_scheduler: table of single-channel frames, hand
// sequences for arbitration order, rejection, watchdog, reset and ID wrap,
// then randomized request traffic checked against a reference model.
module tb_udp_tx_scheduler;

    localparam int NCH  = 4;
    localparam int IFG  = 12;
    localparam int TMO  = 4096;
    localparam int MAXP = 1472;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NCH-1:0]    req;
    logic [15:0]       len  [NCH];
    logic [15:0]       src  [NCH];
    logic [15:0]       dst  [NCH];
    logic [15:0]       cs   [NCH];
    logic [31:0]       dat  [NCH];
    logic [16*NCH-1:0] len_v, src_v, dst_v, cs_v;
    logic [32*NCH-1:0] dat_v;
    logic              tx_data_in_rd, tx_eop;

    logic [NCH-1:0]    ch_data_rd, ch_grant, ch_done;
    logic              ch_err, tx_start, busy, timeout_err;
    logic [15:0]       tx_len, tx_src, tx_dst, tx_cs, tx_tot, tx_id;
    logic [31:0]       tx_data_in;

    always_comb begin
        len_v = '0; src_v = '0; dst_v = '0; cs_v = '0; dat_v = '0;
        for (int i = 0; i < NCH; i++) begin
            len_v[16*i +: 16] = len[i];
            src_v[16*i +: 16] = src[i];
            dst_v[16*i +: 16] = dst[i];
            cs_v[16*i +: 16]  = cs[i];
            dat_v[32*i +: 32] = dat[i];
        end
    end

    udp_tx_scheduler #(
        .NUM_CH(NCH), .IFG_CYCLES(IFG), .MAX_PAYLOAD(MAXP),
        .TIMEOUT(TMO), .ID_INIT(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .ch_req(req), .ch_len(len_v),
        .ch_src_port(src_v), .ch_dst_port(dst_v), .ch_data_chksum(cs_v),
        .ch_data(dat_v), .ch_data_rd(ch_data_rd), .ch_grant(ch_grant),
        .ch_done(ch_done), .ch_err(ch_err), .tx_start(tx_start),
        .tx_udp_data_length(tx_len), .tx_udp_src_port(tx_src),
        .tx_udp_dst_port(tx_dst), .tx_udp_data_chksum(tx_cs),
        .tx_ip_total_len(tx_tot), .tx_ip_id(tx_id), .tx_data_in(tx_data_in),
        .tx_data_in_rd(tx_data_in_rd), .tx_eop(tx_eop), .busy(busy),
        .timeout_err(timeout_err)
    );

    // Second instance: ID counter starting at FFFF, zero inter-frame gap.
    logic [1:0]  b_req, b_rd_o, b_grant, b_done;
    logic        b_err, b_start, b_busy, b_tmo, b_eop;
    logic [15:0] b_len, b_src, b_dst, b_cs, b_tot, b_id;
    logic [31:0] b_data;

    udp_tx_scheduler #(
        .NUM_CH(2), .IFG_CYCLES(0), .MAX_PAYLOAD(MAXP),
        .TIMEOUT(64), .ID_INIT(16'hFFFF)
    ) dut2 (
        .clk(clk), .rst(rst), .ch_req(b_req), .ch_len({16'd20, 16'd6}),
        .ch_src_port({16'd3, 16'd1000}), .ch_dst_port({16'd4, 16'd2000}),
        .ch_data_chksum(32'd0), .ch_data(64'h11111111_22222222),
        .ch_data_rd(b_rd_o), .ch_grant(b_grant), .ch_done(b_done),
        .ch_err(b_err), .tx_start(b_start), .tx_udp_data_length(b_len),
        .tx_udp_src_port(b_src), .tx_udp_dst_port(b_dst),
        .tx_udp_data_chksum(b_cs), .tx_ip_total_len(b_tot), .tx_ip_id(b_id),
        .tx_data_in(b_data), .tx_data_in_rd(1'b0), .tx_eop(b_eop),
        .busy(b_busy), .timeout_err(b_tmo)
    );

    int          ncmp = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          m_rr;
    logic [15:0] m_id;
    int          last_eop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name, input int lim);
        ncmp++;
        nerr++;
        $display("FAIL %s: event not seen within %0d cycles, required", name, lim);
    endtask

    // Reference arbitration: first requester at or after the pointer.
    function automatic int predict();
        for (int k = 0; k < NCH; k++)
            if (req[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
        return -1;
    endfunction

    function automatic int oh2idx(input logic [NCH-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NCH; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy) return;
        end
        bound_fail("wait_idle", 100);
    endtask

    // Runs one arbitration round: waits for start or rejection, checks it
    // against the model, streams nwords payload reads, then ends the frame.
    task automatic serve(input int nwords, input bit do_ifg, output int got,
                         output bit rej, output logic [15:0] tot, output int ecyc);
        int  w;
        bit  seen;
        bit  exp_rej;
        bit  rd;
        w = predict();
        got = -1; rej = 1'b0; tot = '0; ecyc = 0; seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (tx_start || ch_done != '0) seen = 1'b1;
        end
        if (!seen) begin bound_fail("frame_event", 100); return; end
        ecyc = cyc;
        if (w < 0) begin chk("spurious_event", {ch_done, tx_start}, '0); return; end
        exp_rej = (len[w] > 16'(MAXP));
        chk("outcome", {tx_start, ch_done != '0, ch_err}, exp_rej ? 3'b011 : 3'b100);
        if (ch_done != '0) begin
            got = oh2idx(ch_done);
            rej = ch_err;
            chk("reject_winner", got, w);
            chk("reject_grant", ch_grant, '0);
            req[w] = 1'b0;
            m_rr = (w + 1) % NCH;
            return;
        end
        got = oh2idx(ch_grant);
        tot = tx_tot;
        chk("winner", got, w);
        chk("udp_len", tx_len, len[w]);
        chk("src_port", tx_src, src[w]);
        chk("dst_port", tx_dst, dst[w]);
        chk("chksum", tx_cs, cs[w]);
        chk("ip_total_len", tx_tot, len[w] + 16'd28);
        chk("ip_id", tx_id, m_id);
        chk("busy_start", busy, 1'b1);
        if (do_ifg) chk("ifg_spacing", ecyc - last_eop, IFG + 4);
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            rd = 1'($urandom_range(0, 1));
            tx_data_in_rd = rd;
            #1;
            chk("data_route", tx_data_in, dat[w]);
            chk("data_rd", ch_data_rd, rd ? NCH'(1) << w : '0);
            chk("no_early_done", ch_done, '0);
        end
        @(negedge clk);
        tx_data_in_rd = 1'b0;
        tx_eop = 1'b1;
        #1;
        chk("done_on_eop", ch_done, NCH'(1) << w);
        chk("err_on_eop", ch_err, 1'b0);
        last_eop = cyc;
        @(negedge clk);
        tx_eop = 1'b0;
        req[w] = 1'b0;
        chk("grant_dropped", ch_grant, '0);
        chk("no_start_in_gap", tx_start, 1'b0);
        m_id = m_id + 16'd1;
        m_rr = (w + 1) % NCH;
    endtask

    typedef struct {
        int          ch;
        logic [15:0] l;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] c;
        logic [31:0] pd;
        logic [15:0] exp_tot;
        bit          exp_rej;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int          got;
        bit          rej;
        logic [15:0] tot;
        int          ecyc, rcyc, seen_cyc;
        bit          seen;

        tbl[0] = '{0, 16'd6,    16'd1000, 16'd2000, 16'h1234, 32'h12345678, 16'd34,   1'b0};
        tbl[1] = '{0, 16'd6,    16'd1000, 16'd2000, 16'h1234, 32'h12345678, 16'd34,   1'b0};
        tbl[2] = '{1, 16'd1472, 16'h0035, 16'hC000, 16'hFFFF, 32'hDEADBEEF, 16'd1500, 1'b0};
        tbl[3] = '{2, 16'd1473, 16'd5,    16'd6,    16'h0001, 32'h0BADF00D, 16'd0,    1'b1};
        tbl[4] = '{3, 16'd0,    16'd7,    16'd9,    16'h0000, 32'hA5A5A5A5, 16'd28,   1'b0};

        rst = 1'b1; req = '0; tx_data_in_rd = 1'b0; tx_eop = 1'b0;
        b_req = '0; b_eop = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            len[i] = '0; src[i] = '0; dst[i] = '0; cs[i] = '0; dat[i] = '0;
        end
        m_rr = 0; m_id = 16'h0000; last_eop = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", ch_grant, '0);
        chk("rst_start", tx_start, 1'b0);
        chk("rst_id", tx_id, 16'h0000);
        chk("rst_tmo", timeout_err, 1'b0);
        chk("rst_data", tx_data_in, 32'd0);
        chk("rst_id2", b_id, 16'hFFFF);

        // Table: one requester at a time, latency and header fields.
        foreach (tbl[i]) begin
            wait_idle();
            len[tbl[i].ch] = tbl[i].l;  src[tbl[i].ch] = tbl[i].s;
            dst[tbl[i].ch] = tbl[i].d;  cs[tbl[i].ch]  = tbl[i].c;
            dat[tbl[i].ch] = tbl[i].pd;
            req[tbl[i].ch] = 1'b1;
            rcyc = cyc;
            serve(3, 1'b0, got, rej, tot, ecyc);
            chk("tbl_channel", got, tbl[i].ch);
            chk("tbl_reject", rej, tbl[i].exp_rej);
            if (!tbl[i].exp_rej) begin
                chk("tbl_total", tot, tbl[i].exp_tot);
                chk("tbl_latency", ecyc - rcyc, 3);
            end else begin
                chk("tbl_reject_latency", ecyc - rcyc, 1);
            end
        end

        // All channels requesting continuously: order 0,1,2,3,0 and gap.
        wait_idle();
        for (int i = 0; i < NCH; i++) begin
            len[i] = 16'(10 + 5 * i); dat[i] = $urandom;
        end
        req = '1;
        for (int k = 0; k < 5; k++) begin
            serve(2, k > 0, got, rej, tot, ecyc);
            chk("rr_order", got, k % NCH);
            if (got >= 0) req[got] = 1'b1;
        end
        req = '0;

        // Rejection of channel 2 hands the next slot to channel 3.
        wait_idle();
        req[1] = 1'b1;
        serve(1, 1'b0, got, rej, tot, ecyc);
        chk("pre_reject_ch", got, 1);
        wait_idle();
        len[0] = 16'd8; len[2] = 16'd1473; len[3] = 16'd40;
        req = 4'b1101;
        serve(0, 1'b0, got, rej, tot, ecyc);
        chk("reject_ch2", got, 2);
        chk("reject_flag", rej, 1'b1);
        serve(2, 1'b0, got, rej, tot, ecyc);
        chk("after_reject_ch3", got, 3);
        chk("after_reject_ok", rej, 1'b0);
        req = '0;
        wait_idle();
        tx_eop = 1'b1;
        #1;
        chk("eop_idle_ignored", ch_done, '0);
        @(negedge clk);
        tx_eop = 1'b0;
        repeat (4) @(negedge clk);
        chk("dropped_req_ignored", busy, 1'b0);

        // Watchdog: tx_eop withheld for TIMEOUT BUSY cycles.
        len[0] = 16'd10;
        req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        if (!seen) bound_fail("tmo_start", 20);
        chk("tmo_id", tx_id, m_id);
        for (int k = 0; k < TMO; k++) @(negedge clk);
        chk("tmo_not_yet", timeout_err, 1'b0);
        @(negedge clk);
        chk("tmo_set", timeout_err, 1'b1);
        chk("tmo_still_busy", busy, 1'b1);
        chk("tmo_still_grant", ch_grant, 4'b0001);
        @(negedge clk);
        tx_eop = 1'b1;
        #1;
        chk("tmo_late_done", ch_done, 4'b0001);
        chk("tmo_late_err", ch_err, 1'b0);
        @(negedge clk);
        tx_eop = 1'b0; req = '0;
        chk("tmo_sticky", timeout_err, 1'b1);
        chk("tmo_frame_closed", ch_grant, '0);
        m_id = m_id + 16'd1; m_rr = 1;

        // Reset in BUSY clears every output at the next edge.
        wait_idle();
        req[1] = 1'b1; len[1] = 16'd12; dat[1] = 32'hCAFEF00D;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        if (!seen) bound_fail("rst_test_start", 20);
        @(negedge clk);
        tx_data_in_rd = 1'b1;
        #1;
        chk("busy_rd_route", ch_data_rd, 4'b0010);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_grant", ch_grant, '0);
        chk("mid_rst_rd", ch_data_rd, '0);
        chk("mid_rst_data", tx_data_in, 32'd0);
        chk("mid_rst_params", {tx_len, tx_src, tx_dst, tx_cs}, 64'd0);
        chk("mid_rst_total", tx_tot, 16'd0);
        chk("mid_rst_id", tx_id, 16'h0000);
        chk("mid_rst_tmo", timeout_err, 1'b0);
        chk("mid_rst_strobes", {tx_start, ch_done, ch_err}, '0);
        rst = 1'b0; tx_data_in_rd = 1'b0;
        m_rr = 0; m_id = 16'h0000;

        // Randomized request traffic against the model.
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!req[c] && $urandom_range(0, 1) == 1) begin
                    len[c] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(MAXP + 1, 2000))
                                                         : 16'($urandom_range(0, MAXP));
                    src[c] = 16'($urandom); dst[c] = 16'($urandom);
                    cs[c]  = 16'($urandom); dat[c] = $urandom;
                    req[c] = 1'b1;
                end
            end
            if (req == '0) req[it % NCH] = 1'b1;
            serve($urandom_range(0, 4), 1'b0, got, rej, tot, ecyc);
        end
        req = '0;

        // ID wrap with ID_INIT=FFFF and back-to-back frames at zero gap.
        @(negedge clk);
        b_req = 2'b01;
        for (int f = 0; f < 2; f++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (b_start) seen = 1'b1;
            end
            if (!seen) bound_fail("wrap_start", 20);
            chk("wrap_id", b_id, (f == 0) ? 16'hFFFF : 16'h0000);
            chk("wrap_total", b_tot, 16'd34);
            if (f == 1) chk("wrap_zero_gap", cyc - seen_cyc, 5);
            @(negedge clk);
            b_eop = 1'b1;
            #1;
            chk("wrap_done", b_done, 2'b01);
            seen_cyc = cyc;
            @(negedge clk);
            b_eop = 1'b0;
        end
        b_req = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
